// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start bit, DATA_WIDTH payload bits LSB first, optional parity,
// one or two stop bits, with a per-bit prescaler latched at frame acceptance.
module uart_frame_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic                      TX_OUT,
    output logic                      BUSY,
    output logic                      FRAME_DONE
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_e                    state_q,     state_d;
    logic [DATA_WIDTH-1:0]     shift_q,     shift_d;
    logic                      par_bit_q,   par_bit_d;
    logic                      par_en_q,    par_en_d;
    logic                      stop2_q,     stop2_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q,  prescale_d;
    logic [PRESCALE_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0]          bit_cnt_q,   bit_cnt_d;
    logic                      tx_q,        tx_d;
    logic                      busy_q,      busy_d;
    logic                      done_q,      done_d;

    logic [PRESCALE_WIDTH-1:0] bit_len_s;
    logic                      tick_s;

    // A PRESCALE of 0 or 1 both mean one clock per bit.
    assign bit_len_s = (prescale_q > PRESCALE_WIDTH'(1)) ? prescale_q : PRESCALE_WIDTH'(1);
    assign tick_s    = (presc_cnt_q == (bit_len_s - PRESCALE_WIDTH'(1)));

    // Next-state, counters and next output values; outputs are registered from these.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        par_en_d    = par_en_q;
        stop2_d     = stop2_q;
        prescale_d  = prescale_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        presc_cnt_d = tick_s ? {PRESCALE_WIDTH{1'b0}} : (presc_cnt_q + PRESCALE_WIDTH'(1));

        case (state_q)
            ST_IDLE: begin
                tx_d        = 1'b1;
                busy_d      = 1'b0;
                presc_cnt_d = {PRESCALE_WIDTH{1'b0}};
                bit_cnt_d   = {CNT_W{1'b0}};
                if (DATA_VALID) begin
                    state_d    = ST_START;
                    shift_d    = P_DATA;
                    par_bit_d  = calc_parity(P_DATA, PAR_TYP);
                    par_en_d   = PAR_EN;
                    stop2_d    = STOP2;
                    prescale_d = PRESCALE;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = {CNT_W{1'b0}};
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Current bit sits in shift_q[0]; the next one is shift_q[1].
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    state_d   = ST_STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (stop2_q && (bit_cnt_q == {CNT_W{1'b0}})) begin
                        bit_cnt_d = CNT_W'(1);
                    end else begin
                        state_d   = ST_IDLE;
                        tx_d      = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        bit_cnt_d = {CNT_W{1'b0}};
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                tx_d        = 1'b1;
                busy_d      = 1'b0;
                presc_cnt_d = {PRESCALE_WIDTH{1'b0}};
                bit_cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers; reset parks the line high and clears all latches.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            shift_q     <= {DATA_WIDTH{1'b0}};
            par_bit_q   <= 1'b0;
            par_en_q    <= 1'b0;
            stop2_q     <= 1'b0;
            prescale_q  <= {PRESCALE_WIDTH{1'b0}};
            presc_cnt_q <= {PRESCALE_WIDTH{1'b0}};
            bit_cnt_q   <= {CNT_W{1'b0}};
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            par_bit_q   <= par_bit_d;
            par_en_q    <= par_en_d;
            stop2_q     <= stop2_d;
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign TX_OUT     = tx_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: expected line levels per clock are queued when a
// frame is requested and compared cycle by cycle while the frame is on the wire.
module tb_uart_frame_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] pdata8;
    logic [4:0] pdata5;
    logic       dv8;
    logic       dv5;
    logic       par_en;
    logic       par_typ;
    logic       stop2;
    logic [5:0] prescale;
    logic       tx8, busy8, done8;
    logic       tx5, busy5, done5;
    logic       sel;
    logic       tx_m, busy_m, done_m;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    uart_frame_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut8 (
        .CLK(clk), .RST(rst_n), .P_DATA(pdata8), .DATA_VALID(dv8),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .PRESCALE(prescale),
        .TX_OUT(tx8), .BUSY(busy8), .FRAME_DONE(done8)
    );

    uart_frame_tx #(.DATA_WIDTH(5), .PRESCALE_WIDTH(6)) dut5 (
        .CLK(clk), .RST(rst_n), .P_DATA(pdata5), .DATA_VALID(dv5),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .PRESCALE(prescale),
        .TX_OUT(tx5), .BUSY(busy5), .FRAME_DONE(done5)
    );

    assign tx_m   = sel ? tx5   : tx8;
    assign busy_m = sel ? busy5 : busy8;
    assign done_m = sel ? done5 : done8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level for every clock of one frame.
    task automatic push_frame(input int dw, input int data, input bit pe, input bit pt,
                              input bit s2, input int ps);
        int p;
        int par;
        p   = (ps <= 1) ? 1 : ps;
        par = pt ? 1 : 0;
        for (int i = 0; i < dw; i++) par = par ^ ((data >> i) & 1);
        repeat (p) exp_q.push_back(1'b0);
        for (int i = 0; i < dw; i++) repeat (p) exp_q.push_back(((data >> i) & 1) != 0);
        if (pe) repeat (p) exp_q.push_back(par != 0);
        repeat (p) exp_q.push_back(1'b1);
        if (s2) repeat (p) exp_q.push_back(1'b1);
    endtask

    task automatic request(input bit use5, input int data, input bit pe, input bit pt,
                           input bit s2, input int ps);
        sel      = use5;
        pdata8   = 8'(data);
        pdata5   = 5'(data);
        par_en   = pe;
        par_typ  = pt;
        stop2    = s2;
        prescale = 6'(ps);
        if (use5) dv5 = 1'b1;
        else      dv8 = 1'b1;
        push_frame(use5 ? 5 : 8, data, pe, pt, s2, ps);
    endtask

    // Called at the negedge after the accepting edge; walks the frame to its end.
    task automatic play_frame(input bit hold, input int glitch_at, input int abort_at);
        int n;
        n = 0;
        while (exp_q.size() > 0) begin
            if (n == 0 && !hold) begin
                dv8 = 1'b0;
                dv5 = 1'b0;
            end
            if (n == glitch_at) begin
                pdata8   = 8'hFF;
                dv8      = 1'b1;
                par_en   = 1'b1;
                stop2    = 1'b1;
                prescale = 6'd7;
            end
            if (n == glitch_at + 1) dv8 = 1'b0;
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_tx", tx_m, 1'b1);
                check_eq("rst_busy", busy_m, 1'b0);
                check_eq("rst_done", done_m, 1'b0);
                exp_q.delete();
                return;
            end
            check_eq("busy", busy_m, 1'b1);
            check_eq("done_lo", done_m, 1'b0);
            check_eq("tx", tx_m, exp_q.pop_front());
            n++;
            @(negedge clk);
        end
        check_eq("busy_end", busy_m, 1'b0);
        check_eq("done_pulse", done_m, 1'b1);
        check_eq("tx_idle", tx_m, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        sel      = 1'b0;
        pdata8   = 8'h00;
        pdata5   = 5'h00;
        dv8      = 1'b0;
        dv5      = 1'b0;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        stop2    = 1'b0;
        prescale = 6'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_tx8", tx8, 1'b1);
        check_eq("reset_busy8", busy8, 1'b0);
        check_eq("reset_done8", done8, 1'b0);
        check_eq("reset_tx5", tx5, 1'b1);
        check_eq("reset_busy5", busy5, 1'b0);

        // First acceptance on the first edge after release: 0xA6, even parity, prescale 4.
        rst_n = 1'b1;
        request(1'b0, 8'hA6, 1'b1, 1'b0, 1'b0, 4);
        @(negedge clk);
        play_frame(1'b0, 9999, 9999);

        // Odd parity, long bit time; requested on the FRAME_DONE cycle.
        request(1'b0, 8'h05, 1'b1, 1'b1, 1'b0, 32);
        @(negedge clk);
        play_frame(1'b0, 9999, 9999);

        // No parity, two stop bits, one clock per bit.
        request(1'b0, 8'h30, 1'b0, 1'b0, 1'b1, 1);
        @(negedge clk);
        play_frame(1'b0, 9999, 9999);

        // Mid-frame request and input changes must be ignored.
        request(1'b0, 8'h0A, 1'b0, 1'b0, 1'b0, 3);
        @(negedge clk);
        play_frame(1'b0, 10, 9999);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("no_second_busy", busy_m, 1'b0);
            check_eq("no_second_done", done_m, 1'b0);
        end

        // DATA_VALID held high: back-to-back frames with one idle cycle between.
        request(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 2);
        @(negedge clk);
        play_frame(1'b1, 9999, 9999);
        request(1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 2);
        @(negedge clk);
        play_frame(1'b0, 9999, 9999);

        // Reset during data bit 3, then a clean frame right after release.
        @(negedge clk);
        request(1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 4);
        @(negedge clk);
        play_frame(1'b0, 9999, 17);
        dv8 = 1'b0;
        @(negedge clk);
        check_eq("held_rst_tx", tx_m, 1'b1);
        check_eq("held_rst_busy", busy_m, 1'b0);
        rst_n = 1'b1;
        request(1'b0, 8'h96, 1'b1, 1'b1, 1'b1, 2);
        @(negedge clk);
        play_frame(1'b0, 9999, 9999);

        // Five-bit instance: 0x15, even parity, prescale 2 -> 16 busy cycles.
        @(negedge clk);
        request(1'b1, 5'h15, 1'b1, 1'b0, 1'b0, 2);
        @(negedge clk);
        play_frame(1'b0, 9999, 9999);

        // Prescale 0 behaves as one clock per bit.
        request(1'b1, 5'h0B, 1'b0, 1'b0, 1'b1, 0);
        @(negedge clk);
        play_frame(1'b0, 9999, 9999);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
